cdf_feeder: RTL and testbench
=============================

Name: cdf_feeder

Overview:
Initiator side of the divider interface in the histogram-equalisation path. After a start pulse it walks every histogram bin, builds the running cumulative sum and scales it to 8 bits. It hands each CDF value to the divider with a one-cycle enable pulse, waits for ready, and writes the returned g value into the equalisation LUT at the same bin index. Sits between the histogram RAM and the divider/LUT RAM.

Parameters:
NUM_BINS, 256, number of histogram bins / LUT entries
ADDR_W, 8, bin/LUT address width (clog2 NUM_BINS)
BIN_W, 16, histogram bin count width
ACC_W, 24, cumulative accumulator width
CDF_SHIFT, 8, right shift applied to accumulator to form 8-bit CDF
TIMEOUT_CYCLES, 64, watchdog limit (used only with CDF_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle request to process all bins
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after last LUT write
hist_rd_en  out  1  histogram RAM read strobe
hist_addr  out  ADDR_W  histogram RAM address
hist_data  in  BIN_W  bin count, valid the cycle after hist_rd_en
div_enable  out  1  one-cycle request to divider
div_cdf  out  8  CDF value to divider (cdf_in), held stable until div_ready
div_g  in  8  divider result (g_out)
div_ready  in  1  divider result valid (ready_g_out)
lut_we  out  1  LUT write strobe
lut_addr  out  ADDR_W  LUT write address
lut_data  out  8  LUT write data
err  out  1  sticky divider-timeout flag (constant 0 without CDF_TIMEOUT_EN)

Behaviour:
- Reset (asynchronous, active low; clock and reset ports are clk and reset): state IDLE, idx=0, acc=0; busy, done, hist_rd_en, div_enable, lut_we, err=0; hist_addr, lut_addr, div_cdf, lut_data=0. Reset mid-run aborts with no done pulse; no partial state survives.
- FSM: IDLE, READ, ACCUM, ISSUE, WAIT, WRITE, FIN.
- IDLE: start=1 -> READ; clear acc, idx=0, busy=1. start while busy is ignored.
- READ: hist_rd_en=1, hist_addr=idx, 1 cycle -> ACCUM.
- ACCUM: acc <= sat(acc + hist_data) at ACC_W (saturates at 2^ACC_W-1, no wrap); div_cdf <= min(sum >> CDF_SHIFT, 255) using the new sum -> ISSUE.
- ISSUE: div_enable=1 for exactly one cycle -> WAIT. div_ready is ignored in this cycle.
- WAIT: div_enable=0, div_cdf held. On the first cycle with div_ready=1, capture div_g -> WRITE.
- WRITE: lut_we=1, lut_addr=idx, lut_data=captured g, 1 cycle. If idx==NUM_BINS-1 -> FIN, else idx++ -> READ.
- FIN: done=1 for one cycle, busy=0 -> IDLE. acc retains its final value until the next start.
- Per-bin latency: 4 cycles plus divider response time (cycles spent in WAIT, minimum 1).
- The idx counter never wraps past NUM_BINS-1. Bins are always processed 0..NUM_BINS-1 in order.

Optional Feature:
CDF_TIMEOUT_EN
- Defined: a counter runs in WAIT. If div_ready has not arrived after TIMEOUT_CYCLES cycles, set err=1 (sticky until reset or next accepted start), take the WRITE path with lut_data=8'h00, and continue with the next bin.
- Undefined: no counter; WAIT lasts indefinitely; err tied to 0.

Decomposition:
- Package cdf_pkg: FSM state enum, default widths (ADDR_W, BIN_W, ACC_W), CDF_MAX=8'd255, saturating-add and scale function.
- Sub-module cdf_accum: accumulator register with clear, saturating add, shift and clamp to an 8-bit CDF. The FSM, counters and handshakes stay in cdf_feeder.

Test Plan:
- Reset held low mid-WAIT with div_ready never asserted -> all outputs 0 immediately, no done. After release, a start runs cleanly from bin 0.
- NUM_BINS=4, CDF_SHIFT=0, hist={1,2,3,4}, model divider returns g=cdf+1 with ready 3 cycles after enable -> div_cdf sequence 1,3,6,10; LUT[0..3]=2,4,7,11; done 1 cycle after last lut_we.
- Bin counts 16'hFFFF on all 256 bins, ACC_W=16 -> acc saturates at 16'hFFFF; div_cdf clamps to 255; no wrap.
- Start pulsed again while busy -> ignored; exactly NUM_BINS lut_we pulses; a single done.
- div_ready high during the ISSUE cycle and again 2 cycles later -> only the WAIT-cycle value is captured and written.
- CDF_TIMEOUT_EN, TIMEOUT_CYCLES=8, divider silent on bin 2 -> err=1; LUT[2]=0; bins 3.. complete normally; done asserted.

Source files
------------

// File: rtl/cdf_pkg.sv
// Shared definitions for the CDF feeder: FSM state type, default widths and the
// saturating-add / scale helpers used by the accumulator.
package cdf_pkg;

  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned DEF_BIN_W  = 16;
  localparam int unsigned DEF_ACC_W  = 24;

  localparam logic [7:0] CDF_MAX = 8'd255;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StAccum,
    StIssue,
    StWait,
    StWrite,
    StFin
  } cdf_state_e;

  // Saturating add at 'width' bits (width <= 32). Operands are zero-extended by the caller.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned width);
    logic [31:0] sum;
    logic [31:0] lim;
    sum = a + b;
    lim = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    // sum < a catches a 32-bit carry-out
    return ((sum < a) || (sum > lim)) ? lim : sum;
  endfunction

  // Right-shift the running sum and clamp to an 8-bit CDF value.
  function automatic logic [7:0] scale_cdf(input logic [31:0] sum, input int unsigned shift);
    logic [31:0] s;
    s = sum >> shift;
    return (s > {24'd0, CDF_MAX}) ? CDF_MAX : s[7:0];
  endfunction

endpackage

// File: rtl/cdf_feeder_if.sv
// Bus bundle between the CDF feeder and its environment (control, histogram RAM read port,
// divider handshake, LUT write port).
//   master : the feeder (drives strobes, addresses, div_cdf, LUT data, status)
//   slave  : the environment (drives start, hist_data, div_g, div_ready)
interface cdf_feeder_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned BIN_W  = 16
);
  logic              start;
  logic              busy;
  logic              done;
  logic              hist_rd_en;
  logic [ADDR_W-1:0] hist_addr;
  logic [BIN_W-1:0]  hist_data;
  logic              div_enable;
  logic [7:0]        div_cdf;
  logic [7:0]        div_g;
  logic              div_ready;
  logic              lut_we;
  logic [ADDR_W-1:0] lut_addr;
  logic [7:0]        lut_data;
  logic              err;

  modport master (
    input  start, hist_data, div_g, div_ready,
    output busy, done, hist_rd_en, hist_addr, div_enable, div_cdf, lut_we, lut_addr,
           lut_data, err
  );

  modport slave (
    output start, hist_data, div_g, div_ready,
    input  busy, done, hist_rd_en, hist_addr, div_enable, div_cdf, lut_we, lut_addr,
           lut_data, err
  );
endinterface

// File: rtl/cdf_accum.sv
// Running cumulative-sum register for the CDF feeder.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clear_i       : zero the accumulator (CDF output keeps its last value)
//   add_i         : add bin_i with saturation at ACC_W bits and refresh cdf_o
//   bin_i         : histogram bin count
//   cdf_o         : (new sum >> CDF_SHIFT) clamped to 255, registered
module cdf_accum
  import cdf_pkg::*;
#(
  parameter int unsigned BIN_W     = DEF_BIN_W,
  parameter int unsigned ACC_W     = DEF_ACC_W,
  parameter int unsigned CDF_SHIFT = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             add_i,
  input  logic [BIN_W-1:0] bin_i,
  output logic [7:0]       cdf_o
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       cdf_q, cdf_d;
  logic [31:0]      sum;

  always_comb begin
    sum   = sat_add(32'(acc_q), 32'(bin_i), ACC_W);
    acc_d = acc_q;
    cdf_d = cdf_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (add_i) begin
      acc_d = ACC_W'(sum);
      cdf_d = scale_cdf(sum, CDF_SHIFT);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
      cdf_q <= '0;
    end else begin
      acc_q <= acc_d;
      cdf_q <= cdf_d;
    end
  end

  assign cdf_o = cdf_q;

endmodule

// File: rtl/cdf_feeder.sv
// CDF feeder: on start, walks histogram bins 0..NUM_BINS-1, builds the saturating cumulative
// sum, hands each scaled 8-bit CDF value to the divider (one-cycle div_enable, div_cdf held),
// waits for div_ready and writes the returned g into the LUT at the same index.
//   clk   : clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : cdf_feeder_if.master (start/busy/done, histogram read, divider, LUT write, err)
// Optional build macro CDF_TIMEOUT_EN: adds a WAIT watchdog of TIMEOUT_CYCLES cycles; on
// expiry err is set (sticky until reset or next accepted start) and 0 is written to the LUT.
// Without it err is tied low and WAIT lasts until div_ready.
module cdf_feeder
  import cdf_pkg::*;
#(
  parameter int unsigned NUM_BINS       = 256,
  parameter int unsigned ADDR_W         = DEF_ADDR_W,
  parameter int unsigned BIN_W          = DEF_BIN_W,
  parameter int unsigned ACC_W          = DEF_ACC_W,
  parameter int unsigned CDF_SHIFT      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic          clk,
  input logic          reset,
  cdf_feeder_if.master bus
);

  if ((NUM_BINS > (1 << ADDR_W)) || (ACC_W > 32) || (TIMEOUT_CYCLES == 0)) begin : g_bad_params
    $error("cdf_feeder: unsupported parameter combination");
  end

  cdf_state_e        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [7:0]        g_q, g_d;
  logic [7:0]        cdf;
  logic              accept;
  logic              last_bin;
  logic              timeout;

  assign accept   = (state_q == StIdle) && bus.start;
  assign last_bin = (idx_q == ADDR_W'(NUM_BINS - 1));

  cdf_accum #(
    .BIN_W    (BIN_W),
    .ACC_W    (ACC_W),
    .CDF_SHIFT(CDF_SHIFT)
  ) u_accum (
    .clk_i  (clk),
    .rst_ni (reset),
    .clear_i(accept),
    .add_i  (state_q == StAccum),
    .bin_i  (bus.hist_data),
    .cdf_o  (cdf)
  );

`ifdef CDF_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;

  // div_ready in the final counted cycle still wins over the timeout
  assign timeout = (state_q == StWait) && !bus.div_ready &&
                   (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_d = (state_q == StWait) ? tmo_q + 1'b1 : '0;
    err_d = err_q;
    if (accept) begin
      err_d = 1'b0;
    end else if (timeout) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StRead;
      StRead:  state_d = StAccum;
      StAccum: state_d = StIssue;
      StIssue: state_d = StWait;  // div_ready ignored here
      StWait:  if (bus.div_ready || timeout) state_d = StWrite;
      StWrite: state_d = last_bin ? StFin : StRead;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Bin index and captured divider result
  always_comb begin
    idx_d = idx_q;
    g_d   = g_q;
    if (accept) begin
      idx_d = '0;
    end else if ((state_q == StWrite) && !last_bin) begin
      idx_d = idx_q + 1'b1;
    end
    if (state_q == StWait) begin
      if (bus.div_ready) begin
        g_d = bus.div_g;
      end else if (timeout) begin
        g_d = 8'h00;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q <= '0;
      g_q   <= '0;
    end else begin
      idx_q <= idx_d;
      g_q   <= g_d;
    end
  end

  // Outputs
  always_comb begin
    bus.busy       = 1'b0;
    bus.done       = 1'b0;
    bus.hist_rd_en = 1'b0;
    bus.div_enable = 1'b0;
    bus.lut_we     = 1'b0;
    bus.hist_addr  = idx_q;
    bus.lut_addr   = idx_q;
    bus.lut_data   = g_q;
    bus.div_cdf    = cdf;
`ifdef CDF_TIMEOUT_EN
    bus.err        = err_q;
`else
    bus.err        = 1'b0;
`endif
    unique case (state_q)
      StRead:  begin bus.busy = 1'b1; bus.hist_rd_en = 1'b1; end
      StAccum: bus.busy = 1'b1;
      StIssue: begin bus.busy = 1'b1; bus.div_enable = 1'b1; end
      StWait:  bus.busy = 1'b1;
      StWrite: begin bus.busy = 1'b1; bus.lut_we = 1'b1; end
      StFin:   bus.done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cdf_feeder.sv
// Bench for cdf_feeder: a 4-bin instance (CDF_SHIFT=0) driven from a table of runs, and a
// 256-bin instance with ACC_W=16 for saturation/clamping. Divider and histogram RAM are
// modelled at the falling edge.
module tb_cdf_feeder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cdf_feeder_if #(.ADDR_W(2), .BIN_W(16)) bus_a ();
  cdf_feeder_if #(.ADDR_W(8), .BIN_W(16)) bus_b ();

  cdf_feeder #(
    .NUM_BINS(4), .ADDR_W(2), .BIN_W(16), .ACC_W(24), .CDF_SHIFT(0), .TIMEOUT_CYCLES(8)
  ) dut_a (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_a)
  );

  cdf_feeder #(
    .NUM_BINS(256), .ADDR_W(8), .BIN_W(16), .ACC_W(16), .CDF_SHIFT(8), .TIMEOUT_CYCLES(64)
  ) dut_b (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- 4-bin instance environment ----------------
  logic [15:0] hist_a [4];
  int          lat_a, silent_bin_a, cnt_a;
  bit          glitch_a, silent_all_a, pend_a;
  logic [7:0]  cdf_log_a [8];
  logic [1:0]  lut_addr_log_a [8];
  logic [7:0]  lut_data_log_a [8];
  int          n_cdf_a, n_lut_a, n_done_a, last_we_a, done_cyc_a;
  int          cyc = 0;

  always @(negedge clk) begin
    cyc++;
    bus_a.div_ready = 1'b0;
    if (!reset) begin
      pend_a = 1'b0;
    end else begin
      if (bus_a.hist_rd_en) bus_a.hist_data = hist_a[bus_a.hist_addr];
      if (bus_a.lut_we) begin
        if (n_lut_a < 8) begin
          lut_addr_log_a[n_lut_a] = bus_a.lut_addr;
          lut_data_log_a[n_lut_a] = bus_a.lut_data;
        end
        n_lut_a++;
        last_we_a = cyc;
      end
      if (bus_a.done) begin
        n_done_a++;
        done_cyc_a = cyc;
      end
      if (bus_a.div_enable) begin
        if (n_cdf_a < 8) cdf_log_a[n_cdf_a] = bus_a.div_cdf;
        pend_a = !silent_all_a && (n_cdf_a != silent_bin_a);
        cnt_a  = 0;
        n_cdf_a++;
        if (glitch_a) begin
          // response during ISSUE that must not be captured
          bus_a.div_ready = 1'b1;
          bus_a.div_g     = 8'hEE;
        end
      end else if (pend_a) begin
        cnt_a++;
        if (cnt_a >= lat_a) begin
          bus_a.div_ready = 1'b1;
          bus_a.div_g     = bus_a.div_cdf + 8'd1;
          pend_a          = 1'b0;
        end
      end
    end
  end

  // ---------------- 256-bin instance environment ----------------
  logic [15:0] hist_b [256];
  logic [7:0]  cdf_log_b [256];
  logic [7:0]  lut_addr_log_b [256];
  logic [7:0]  lut_data_log_b [256];
  int          n_cdf_b, n_lut_b, n_done_b;
  bit          pend_b;

  always @(negedge clk) begin
    bus_b.div_ready = 1'b0;
    if (!reset) begin
      pend_b = 1'b0;
    end else begin
      if (bus_b.hist_rd_en) bus_b.hist_data = hist_b[bus_b.hist_addr];
      if (bus_b.lut_we) begin
        if (n_lut_b < 256) begin
          lut_addr_log_b[n_lut_b] = bus_b.lut_addr;
          lut_data_log_b[n_lut_b] = bus_b.lut_data;
        end
        n_lut_b++;
      end
      if (bus_b.done) n_done_b++;
      if (bus_b.div_enable) begin
        if (n_cdf_b < 256) cdf_log_b[n_cdf_b] = bus_b.div_cdf;
        n_cdf_b++;
        pend_b = 1'b1;
      end else if (pend_b) begin
        bus_b.div_ready = 1'b1;  // one WAIT cycle
        bus_b.div_g     = bus_b.div_cdf ^ 8'hA5;
        pend_b          = 1'b0;
      end
    end
  end

  // ---------------- run table ----------------
  typedef struct {
    logic [0:3][15:0] hist;
    int               lat;
    bit               glitch;
    bit               restart;
    int               silent_bin;
    logic [0:3][7:0]  exp_cdf;
    logic [0:3][7:0]  exp_lut;
    bit               exp_err;
  } run_t;

  run_t rows [6];
  int   n_rows;

  task automatic run_a(input run_t r, input string tag);
    for (int i = 0; i < 4; i++) hist_a[i] = r.hist[i];
    lat_a        = r.lat;
    glitch_a     = r.glitch;
    silent_bin_a = r.silent_bin;
    n_cdf_a      = 0;
    n_lut_a      = 0;
    n_done_a     = 0;
    last_we_a    = -1;
    done_cyc_a   = -2;
    @(negedge clk);
    bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    check({tag, " busy after start"}, bus_a.busy, 1);
    check({tag, " err cleared by start"}, bus_a.err, 0);
    if (r.restart) begin
      repeat (5) @(negedge clk);
      bus_a.start = 1'b1;
      @(negedge clk);
      bus_a.start = 1'b0;
    end
    for (int i = 0; i < 400 && n_done_a == 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check({tag, " done pulses"}, n_done_a, 1);
    check({tag, " lut_we pulses"}, n_lut_a, 4);
    check({tag, " div_enable pulses"}, n_cdf_a, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s div_cdf[%0d]", tag, i), cdf_log_a[i], r.exp_cdf[i]);
      check($sformatf("%s lut_addr[%0d]", tag, i), lut_addr_log_a[i], i);
      check($sformatf("%s lut_data[%0d]", tag, i), lut_data_log_a[i], r.exp_lut[i]);
    end
    check({tag, " done one cycle after last lut_we"}, done_cyc_a, last_we_a + 1);
    check({tag, " busy after done"}, bus_a.busy, 0);
    check({tag, " err after run"}, bus_a.err, r.exp_err);
  endtask

  task automatic run_b(input bit ramp, input string tag);
    logic [7:0] e;
    for (int i = 0; i < 256; i++) hist_b[i] = ramp ? 16'h0100 : 16'hFFFF;
    n_cdf_b  = 0;
    n_lut_b  = 0;
    n_done_b = 0;
    @(negedge clk);
    bus_b.start = 1'b1;
    @(negedge clk);
    bus_b.start = 1'b0;
    for (int i = 0; i < 3000 && n_done_b == 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check({tag, " done pulses"}, n_done_b, 1);
    check({tag, " lut_we pulses"}, n_lut_b, 256);
    for (int i = 0; i < 256; i++) begin
      // ramp: sum=(i+1)*256, last bin saturates at 16'hFFFF; flat: saturated from bin 0
      e = (ramp && i < 255) ? 8'(i + 1) : 8'd255;
      check($sformatf("%s div_cdf[%0d]", tag, i), cdf_log_b[i], e);
      check($sformatf("%s lut_addr[%0d]", tag, i), lut_addr_log_b[i], i);
      check($sformatf("%s lut_data[%0d]", tag, i), lut_data_log_b[i], e ^ 8'hA5);
    end
    check({tag, " err"}, bus_b.err, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rows[0] = '{hist: {16'd1, 16'd2, 16'd3, 16'd4}, lat: 3, glitch: 1'b0, restart: 1'b0,
                silent_bin: -1, exp_cdf: {8'd1, 8'd3, 8'd6, 8'd10},
                exp_lut: {8'd2, 8'd4, 8'd7, 8'd11}, exp_err: 1'b0};
    rows[1] = '{hist: {16'd100, 16'd100, 16'd60, 16'd0}, lat: 1, glitch: 1'b0, restart: 1'b1,
                silent_bin: -1, exp_cdf: {8'd100, 8'd200, 8'd255, 8'd255},
                exp_lut: {8'd101, 8'd201, 8'd0, 8'd0}, exp_err: 1'b0};
    rows[2] = '{hist: {16'd0, 16'd0, 16'd5, 16'd255}, lat: 2, glitch: 1'b1, restart: 1'b0,
                silent_bin: -1, exp_cdf: {8'd0, 8'd0, 8'd5, 8'd255},
                exp_lut: {8'd1, 8'd1, 8'd6, 8'd0}, exp_err: 1'b0};
    rows[3] = '{hist: {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, lat: 1, glitch: 1'b0,
                restart: 1'b0, silent_bin: -1, exp_cdf: {8'd255, 8'd255, 8'd255, 8'd255},
                exp_lut: {8'd0, 8'd0, 8'd0, 8'd0}, exp_err: 1'b0};
    n_rows = 4;
`ifdef CDF_TIMEOUT_EN
    rows[n_rows] = '{hist: {16'd1, 16'd2, 16'd3, 16'd4}, lat: 3, glitch: 1'b0, restart: 1'b0,
                     silent_bin: 2, exp_cdf: {8'd1, 8'd3, 8'd6, 8'd10},
                     exp_lut: {8'd2, 8'd4, 8'd0, 8'd11}, exp_err: 1'b1};
    n_rows++;
`endif
    rows[n_rows] = '{hist: {16'd7, 16'd0, 16'd9, 16'd1}, lat: 4, glitch: 1'b0, restart: 1'b0,
                     silent_bin: -1, exp_cdf: {8'd7, 8'd7, 8'd16, 8'd17},
                     exp_lut: {8'd8, 8'd8, 8'd17, 8'd18}, exp_err: 1'b0};
    n_rows++;

    bus_a.start = 1'b0; bus_a.hist_data = '0; bus_a.div_g = '0; bus_a.div_ready = 1'b0;
    bus_b.start = 1'b0; bus_b.hist_data = '0; bus_b.div_g = '0; bus_b.div_ready = 1'b0;
    lat_a = 1; glitch_a = 1'b0; silent_all_a = 1'b0; silent_bin_a = -1;
    n_cdf_a = 0; n_lut_a = 0; n_done_a = 0; n_cdf_b = 0; n_lut_b = 0; n_done_b = 0;

    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    check("reset busy", bus_a.busy, 0);
    check("reset done", bus_a.done, 0);
    check("reset hist_rd_en", bus_a.hist_rd_en, 0);
    check("reset div_enable", bus_a.div_enable, 0);
    check("reset lut_we", bus_a.lut_we, 0);
    check("reset div_cdf", bus_a.div_cdf, 0);
    check("reset err", bus_a.err, 0);
    check("reset b busy", bus_b.busy, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    for (int r = 0; r < n_rows; r++) run_a(rows[r], $sformatf("row%0d", r));

    // Reset while waiting on a silent divider: everything clears at once, no done.
    silent_all_a = 1'b1;
    glitch_a     = 1'b0;
    silent_bin_a = -1;
    for (int i = 0; i < 4; i++) hist_a[i] = rows[0].hist[i];
    n_cdf_a = 0; n_lut_a = 0; n_done_a = 0;
    @(negedge clk);
    bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    for (int i = 0; i < 50 && n_cdf_a == 0; i++) @(negedge clk);
    check("midrun enable seen", n_cdf_a, 1);
    repeat (2) @(negedge clk);
    check("midrun busy before reset", bus_a.busy, 1);
    check("midrun div_cdf before reset", bus_a.div_cdf, 1);
    #2 reset = 1'b0;
    #1;
    check("midrun reset busy", bus_a.busy, 0);
    check("midrun reset done", bus_a.done, 0);
    check("midrun reset hist_rd_en", bus_a.hist_rd_en, 0);
    check("midrun reset hist_addr", bus_a.hist_addr, 0);
    check("midrun reset div_enable", bus_a.div_enable, 0);
    check("midrun reset div_cdf", bus_a.div_cdf, 0);
    check("midrun reset lut_we", bus_a.lut_we, 0);
    check("midrun reset lut_addr", bus_a.lut_addr, 0);
    check("midrun reset lut_data", bus_a.lut_data, 0);
    check("midrun reset err", bus_a.err, 0);
    repeat (3) @(negedge clk);
    check("midrun no done", n_done_a, 0);
    check("midrun no lut_we", n_lut_a, 0);
    reset        = 1'b1;
    silent_all_a = 1'b0;
    repeat (2) @(negedge clk);
    run_a(rows[0], "post-reset");

    run_b(1'b0, "sat-flat");
    run_b(1'b1, "sat-ramp");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
